// File: rtl/limb_bus_pkg.sv
// Shared bus encodings for the processor's memory port: transfer types, owner IDs,
// protection bit positions and requester indices.
package limb_bus_pkg;

    localparam logic [1:0] TRANS_IDLE = 2'b00;
    localparam logic [1:0] TRANS_BUSY = 2'b01;
    localparam logic [1:0] TRANS_NSEQ = 2'b10;
    localparam logic [1:0] TRANS_SEQ  = 2'b11;

    typedef enum logic [1:0] {
        OWN_NONE  = 2'd0,
        OWN_FETCH = 2'd1,
        OWN_DATA  = 2'd2
    } owner_t;

    localparam int PROT_PRIV_BIT = 1;
    localparam int PROT_DATA_BIT = 0;

    localparam int REQ_FETCH = 0;
    localparam int REQ_DATA  = 1;
    localparam int NUM_REQ   = 2;

    typedef struct packed {
        logic   valid;
        owner_t owner;
    } tag_t;

    function automatic owner_t req_owner(input int idx);
        return (idx == REQ_DATA) ? OWN_DATA : OWN_FETCH;
    endfunction

endpackage

// File: rtl/memory_arbiter_priority.sv
// Data-over-fetch priority with a run counter that hands the port to fetch after
// MAX_DATA_RUN consecutive data grants while fetch is waiting.
module memory_arbiter_priority
    import limb_bus_pkg::*;
#(
    parameter int MAX_DATA_RUN = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt
);

    logic [3:0] run_cnt_q;
    logic [3:0] run_cnt_d;
    logic       fetch_starved;

    always_comb begin
        fetch_starved = req[REQ_FETCH] && (run_cnt_q == 4'(MAX_DATA_RUN));
        gnt           = '0;
        if (req[REQ_DATA] && !fetch_starved) begin
            gnt[REQ_DATA] = 1'b1;
        end else if (req[REQ_FETCH]) begin
            gnt[REQ_FETCH] = 1'b1;
        end

        // Counter only measures how long fetch has been kept waiting.
        run_cnt_d = run_cnt_q;
        if (!req[REQ_FETCH] || gnt[REQ_FETCH]) begin
            run_cnt_d = '0;
        end else if (gnt[REQ_DATA] && (run_cnt_q < 4'(MAX_DATA_RUN))) begin
            run_cnt_d = run_cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            run_cnt_q <= '0;
        end else begin
            run_cnt_q <= run_cnt_d;
        end
    end

endmodule

// File: rtl/memory_arbiter.sv
// Shares the memory_controller port between instruction fetch and load/store: one grant
// per cycle, registered address phase, and a 2-stage tag pipeline that routes responses.
module memory_arbiter
    import limb_bus_pkg::*;
#(
    parameter int   ADDR_WIDTH   = 32,
    parameter int   DATA_WIDTH   = 32,
    parameter int   MAX_DATA_RUN = 4,
    parameter logic PROT_PRIV    = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  f_req,
    input  logic [ADDR_WIDTH-1:0] f_addr,
    output logic                  f_gnt,
    output logic                  f_rvalid,
    output logic [DATA_WIDTH-1:0] f_rdata,
    output logic                  f_abort,
    input  logic                  d_req,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    input  logic                  d_write,
    input  logic                  d_size,
    output logic                  d_gnt,
    output logic                  d_rvalid,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  d_abort,
    output logic [ADDR_WIDTH-1:0] m_addr,
    output logic [DATA_WIDTH-1:0] m_wdata,
    input  logic [DATA_WIDTH-1:0] m_rdata,
    input  logic                  m_abort,
    output logic                  m_write,
    output logic                  m_size,
    output logic [1:0]            m_prot,
    output logic [1:0]            m_trans
);

    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] gnt;

    // Requests are masked during reset so no grant is visible while state clears.
    assign req[REQ_FETCH] = f_req && !reset;
    assign req[REQ_DATA]  = d_req && !reset;

    memory_arbiter_priority #(
        .MAX_DATA_RUN(MAX_DATA_RUN)
    ) u_priority (
        .clk  (clk),
        .reset(reset),
        .req  (req),
        .gnt  (gnt)
    );

    assign f_gnt = gnt[REQ_FETCH];
    assign d_gnt = gnt[REQ_DATA];

    logic [ADDR_WIDTH-1:0] m_addr_q,  m_addr_d;
    logic [DATA_WIDTH-1:0] m_wdata_q, m_wdata_d;
    logic                  m_write_q, m_write_d;
    logic                  m_size_q,  m_size_d;
    logic [1:0]            m_prot_q,  m_prot_d;
    logic [1:0]            m_trans_q, m_trans_d;
    owner_t                owner_q,   owner_d;
    tag_t                  tag1_q,    tag1_d;
    tag_t                  tag2_q,    tag2_d;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [ADDR_WIDTH-1:0] seq_addr;

    assign seq_addr = m_addr_q + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    always_comb begin
        m_addr_d  = m_addr_q;
        m_wdata_d = m_wdata_q;
        m_write_d = 1'b0;
        m_size_d  = m_size_q;
        m_prot_d  = m_prot_q;
        m_trans_d = TRANS_IDLE;
        owner_d   = OWN_NONE;
        req_addr  = m_addr_q;

        if (gnt[REQ_DATA]) begin
            owner_d                 = OWN_DATA;
            req_addr                = d_addr;
            m_wdata_d               = d_wdata;
            m_write_d               = d_write;
            m_size_d                = d_size;
            m_prot_d[PROT_PRIV_BIT] = PROT_PRIV;
            m_prot_d[PROT_DATA_BIT] = 1'b1;
        end else if (gnt[REQ_FETCH]) begin
            owner_d                 = OWN_FETCH;
            req_addr                = f_addr;
            m_wdata_d               = '0;
            m_size_d                = 1'b1;
            m_prot_d[PROT_PRIV_BIT] = PROT_PRIV;
            m_prot_d[PROT_DATA_BIT] = 1'b0;
        end

        // owner_q is NONE after an idle cycle, so the burst restarts with NSEQ.
        if (owner_d != OWN_NONE) begin
            m_addr_d  = req_addr;
            m_trans_d = ((owner_d == owner_q) && (req_addr == seq_addr)) ? TRANS_SEQ : TRANS_NSEQ;
        end

        tag1_d = '{valid: (owner_d != OWN_NONE), owner: owner_d};
        tag2_d = tag1_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            m_addr_q  <= '0;
            m_wdata_q <= '0;
            m_write_q <= 1'b0;
            m_size_q  <= 1'b0;
            m_prot_q  <= '0;
            m_trans_q <= TRANS_IDLE;
            owner_q   <= OWN_NONE;
            tag1_q    <= '0;
            tag2_q    <= '0;
        end else begin
            m_addr_q  <= m_addr_d;
            m_wdata_q <= m_wdata_d;
            m_write_q <= m_write_d;
            m_size_q  <= m_size_d;
            m_prot_q  <= m_prot_d;
            m_trans_q <= m_trans_d;
            owner_q   <= owner_d;
            tag1_q    <= tag1_d;
            tag2_q    <= tag2_d;
        end
    end

    assign m_addr  = m_addr_q;
    assign m_wdata = m_wdata_q;
    assign m_write = m_write_q;
    assign m_size  = m_size_q;
    assign m_prot  = m_prot_q;
    assign m_trans = m_trans_q;

    logic [NUM_REQ-1:0] rvalid_vec;
    logic [NUM_REQ-1:0] abort_vec;

    // The data-phase tag selects which requester sees m_rdata/m_abort; idle slots see nothing.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_resp
        assign rvalid_vec[gi] = !reset && tag2_q.valid && (tag2_q.owner == req_owner(gi));
        assign abort_vec[gi]  = rvalid_vec[gi] && m_abort;
    end

    assign f_rvalid = rvalid_vec[REQ_FETCH];
    assign d_rvalid = rvalid_vec[REQ_DATA];
    assign f_abort  = abort_vec[REQ_FETCH];
    assign d_abort  = abort_vec[REQ_DATA];
    assign f_rdata  = f_rvalid ? m_rdata : '0;
    assign d_rdata  = d_rvalid ? m_rdata : '0;

endmodule

// File: tb/tb_memory_arbiter.sv
// Scoreboard bench for memory_arbiter: a reference arbiter/memory model predicts grants,
// address-phase values and responses, which are compared every cycle.
module tb_memory_arbiter;
    import limb_bus_pkg::*;

    localparam int MAXRUN = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        f_req = 1'b0;
    logic [31:0] f_addr = '0;
    logic        f_gnt, f_rvalid, f_abort;
    logic [31:0] f_rdata;
    logic        d_req = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic        d_write = 1'b0;
    logic        d_size = 1'b0;
    logic        d_gnt, d_rvalid, d_abort;
    logic [31:0] d_rdata;
    logic [31:0] m_addr, m_wdata;
    logic [31:0] m_rdata = '0;
    logic        m_abort = 1'b0;
    logic        m_write, m_size;
    logic [1:0]  m_prot, m_trans;

    always #5 clk = ~clk;

    memory_arbiter #(
        .ADDR_WIDTH  (32),
        .DATA_WIDTH  (32),
        .MAX_DATA_RUN(MAXRUN),
        .PROT_PRIV   (1'b1)
    ) dut (
        .clk(clk), .reset(reset),
        .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid),
        .f_rdata(f_rdata), .f_abort(f_abort),
        .d_req(d_req), .d_addr(d_addr), .d_wdata(d_wdata), .d_write(d_write),
        .d_size(d_size), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .d_abort(d_abort),
        .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata), .m_abort(m_abort),
        .m_write(m_write), .m_size(m_size), .m_prot(m_prot), .m_trans(m_trans)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [31:0] pat(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // Memory environment: responds one cycle after each address phase.
    logic [31:0] env_mem [logic [31:0]];
    logic [31:0] abort_addr = 32'hFFFF_0000;
    logic        pend_v = 1'b0;
    logic        pend_a = 1'b0;
    logic [31:0] pend_d = '0;

    always @(negedge clk) begin
        pend_v = (m_trans != TRANS_IDLE);
        pend_a = m_prot[0] && (m_addr == abort_addr);
        if (pend_v && m_write) begin
            env_mem[m_addr] = m_wdata;
            pend_d = 32'h0;
        end else begin
            pend_d = env_mem.exists(m_addr) ? env_mem[m_addr] : pat(m_addr);
        end
    end

    always @(posedge clk) begin
        #1;
        m_rdata = pend_v ? pend_d : 32'hBAD0_BAD0;
        m_abort = pend_v ? pend_a : 1'b1;
    end

    // Reference model state
    logic [31:0] ref_mem [logic [31:0]];
    int          cyc = 0;
    int          run_m = 0;
    owner_t      own_m = OWN_NONE;
    logic [31:0] prev_addr_m = '0;
    logic [1:0]  e_trans = '0;
    logic [1:0]  e_prot = '0;
    logic [31:0] e_addr = '0;
    logic [31:0] e_wdata = '0;
    logic        e_write = 1'b0;
    logic        e_size = 1'b0;

    typedef struct {
        int          due;
        logic        is_data;
        logic [31:0] data;
        logic        abort;
        logic        chk_data;
    } resp_t;
    resp_t resp_q[$];

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : pat(a);
    endfunction

    task automatic cycle(input logic fr, input logic [31:0] fa, input logic dr,
                         input logic [31:0] da, input logic [31:0] dwd, input logic dwr,
                         output logic fg, output logic dg);
        resp_t r;
        logic  exp_fv, exp_dv, exp_fab, exp_dab;
        @(posedge clk);
        #1;
        reset = 1'b0; f_req = fr; f_addr = fa; d_req = dr; d_addr = da;
        d_wdata = dwd; d_write = dwr; d_size = 1'b0;
        @(negedge clk);

        dg = dr && !(fr && run_m == MAXRUN);
        fg = fr && !dg;
        check_val("f_gnt", 64'(f_gnt), 64'(fg));
        check_val("d_gnt", 64'(d_gnt), 64'(dg));
        check_val("one_gnt", 64'(f_gnt & d_gnt), 64'(0));

        exp_fv = 1'b0; exp_dv = 1'b0; exp_fab = 1'b0; exp_dab = 1'b0;
        r = '{due: -1, is_data: 1'b0, data: 32'h0, abort: 1'b0, chk_data: 1'b0};
        if (resp_q.size() > 0 && resp_q[0].due == cyc) begin
            r = resp_q.pop_front();
            exp_fv = !r.is_data; exp_dv = r.is_data;
            exp_fab = !r.is_data && r.abort; exp_dab = r.is_data && r.abort;
        end
        check_val("rvalid", 64'({f_rvalid, d_rvalid}), 64'({exp_fv, exp_dv}));
        check_val("abort", 64'({f_abort, d_abort}), 64'({exp_fab, exp_dab}));
        if (r.chk_data) begin
            if (r.is_data) check_val("d_rdata", 64'(d_rdata), 64'(r.data));
            else           check_val("f_rdata", 64'(f_rdata), 64'(r.data));
        end

        check_val("m_trans", 64'(m_trans), 64'(e_trans));
        if (e_trans != TRANS_IDLE) begin
            check_val("m_addr", 64'(m_addr), 64'(e_addr));
            check_val("m_wdata", 64'(m_wdata), 64'(e_wdata));
            check_val("m_ctl", 64'({m_write, m_size, m_prot}), 64'({e_write, e_size, e_prot}));
        end else begin
            check_val("m_write_idle", 64'(m_write), 64'(0));
        end

        if (dg) begin
            e_trans = (own_m == OWN_DATA && da == prev_addr_m + 32'd1) ? TRANS_SEQ : TRANS_NSEQ;
            e_addr = da; e_wdata = dwd; e_write = dwr; e_size = 1'b0; e_prot = 2'b11;
            resp_q.push_back('{due: cyc + 2, is_data: 1'b1, data: (dwr ? 32'h0 : ref_rd(da)),
                               abort: (da == abort_addr), chk_data: !dwr});
            if (dwr) ref_mem[da] = dwd;
            own_m = OWN_DATA; prev_addr_m = da;
            $display("txn cyc=%0d data %s addr=%h wdata=%h", cyc, dwr ? "store" : "load", da, dwd);
        end else if (fg) begin
            e_trans = (own_m == OWN_FETCH && fa == prev_addr_m + 32'd1) ? TRANS_SEQ : TRANS_NSEQ;
            e_addr = fa; e_wdata = 32'h0; e_write = 1'b0; e_size = 1'b1; e_prot = 2'b10;
            resp_q.push_back('{due: cyc + 2, is_data: 1'b0, data: ref_rd(fa),
                               abort: 1'b0, chk_data: 1'b1});
            own_m = OWN_FETCH; prev_addr_m = fa;
            $display("txn cyc=%0d fetch addr=%h", cyc, fa);
        end else begin
            e_trans = TRANS_IDLE; e_write = 1'b0; own_m = OWN_NONE;
        end

        if (!fr || fg) run_m = 0;
        else if (dg && run_m < MAXRUN) run_m++;
        cyc++;
    endtask

    task automatic idle(input int n);
        logic fg, dg;
        for (int i = 0; i < n; i++) cycle(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, fg, dg);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset = 1'b1; f_req = 1'b0; d_req = 1'b0; d_write = 1'b0;
        resp_q.delete();
        run_m = 0; own_m = OWN_NONE; prev_addr_m = '0;
        e_trans = '0; e_addr = '0; e_wdata = '0; e_write = 1'b0; e_size = 1'b0; e_prot = '0;
        @(negedge clk);
        check_val("rst_gnt", 64'({f_gnt, d_gnt}), 64'(0));
        check_val("rst_rvalid", 64'({f_rvalid, d_rvalid}), 64'(0));
        @(posedge clk);
        @(negedge clk);
        check_val("rst_ctl", 64'({m_trans, m_prot, m_write, m_size, f_gnt, d_gnt,
                                  f_rvalid, d_rvalid, f_abort, d_abort}), 64'(0));
        check_val("rst_m_addr", 64'(m_addr), 64'(0));
        check_val("rst_m_wdata", 64'(m_wdata), 64'(0));
        check_val("rst_rdata", 64'({f_rdata, d_rdata}), 64'(0));
        cyc += 2;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic        fg, dg;
        logic [31:0] fa, da;

        do_reset();

        // Sequential fetch burst
        for (int k = 0; k < 3; k++) cycle(1'b1, 32'(k), 1'b0, 32'h0, 32'h0, 1'b0, fg, dg);
        idle(3);

        // Contention: expect D,D,D,D,F repeating
        fa = 32'h100; da = 32'h200;
        for (int k = 0; k < 12; k++) begin
            cycle(1'b1, fa, 1'b1, da, 32'h0, 1'b0, fg, dg);
            check_val("t2_pattern", 64'(f_gnt), 64'((k % 5) == 4));
            if (fg) fa++;
            if (dg) da++;
        end
        idle(3);

        // Store then load back
        cycle(1'b0, 32'h0, 1'b1, 32'h5, 32'hCAFE_0001, 1'b1, fg, dg);
        cycle(1'b0, 32'h0, 1'b1, 32'h5, 32'h0, 1'b0, fg, dg);
        idle(2);
        check_val("t3_load", 64'(d_rdata), 64'(32'hCAFE_0001));
        idle(1);

        // Address wrap, then owner change
        cycle(1'b1, 32'hFFFF_FFFF, 1'b0, 32'h0, 32'h0, 1'b0, fg, dg);
        cycle(1'b1, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, fg, dg);
        cycle(1'b1, 32'h3, 1'b0, 32'h0, 32'h0, 1'b0, fg, dg);
        cycle(1'b0, 32'h0, 1'b1, 32'h4, 32'h0, 1'b0, fg, dg);
        idle(3);

        // Aborted load
        abort_addr = 32'h77;
        cycle(1'b0, 32'h0, 1'b1, 32'h77, 32'h0, 1'b0, fg, dg);
        cycle(1'b1, 32'h78, 1'b0, 32'h0, 32'h0, 1'b0, fg, dg);
        idle(3);

        // Reset one cycle after a grant
        cycle(1'b1, 32'h40, 1'b0, 32'h0, 32'h0, 1'b0, fg, dg);
        do_reset();
        idle(2);
        cycle(1'b1, 32'h41, 1'b0, 32'h0, 32'h0, 1'b0, fg, dg);
        cycle(1'b1, 32'h42, 1'b0, 32'h0, 32'h0, 1'b0, fg, dg);
        idle(3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
